// File: rtl/serial_parity_rx_pkg.sv
//------------------------------------------------------------------------------
// Module      : serial_parity_rx_pkg
// Description : Shared definitions for the XOR parity link (state encoding,
//               default width, parity sense). Macro: ODD_PARITY_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_parity_rx_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam int DATA_W_DEFAULT = 8;

`ifdef ODD_PARITY_EN
    localparam logic PARITY_ODD = 1'b1;
`else
    localparam logic PARITY_ODD = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_HOLD   = ST_HOLD
    } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_parity_rx_parity_acc.sv
//------------------------------------------------------------------------------
// Module      : parity_acc (with xor_gate cell)
// Description : Registered 1-bit XOR accumulator with clear and enable.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xor_gate (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a ^ i_b;
endmodule

module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_bit,
    output logic o_acc
);
    logic r_acc;
    logic w_xor;

    xor_gate u_xor (
        .i_a (r_acc),
        .i_b (i_bit),
        .o_y (w_xor)
    );

    // Clear wins over enable so a new frame always starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 1'b0;
        end else if (i_clr) begin
            r_acc <= 1'b0;
        end else if (i_en) begin
            r_acc <= w_xor;
        end
    end

    assign o_acc = r_acc;
endmodule

`default_nettype wire

// File: rtl/serial_parity_rx.sv
//------------------------------------------------------------------------------
// Module      : serial_parity_rx
// Description : Deframes start/data(LSB-first)/parity serial frames into words
//               on a valid/ready port. Macro: ODD_PARITY_EN selects odd parity.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_parity_rx
    import serial_parity_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              overrun
);

    state_e            r_state;
    state_e            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_out_data;
    logic              r_parity_err;
    logic              r_overrun;
    logic              w_acc;
    logic              w_start;
    logic              w_cnt_ok;
    logic              w_last;
    logic              w_data_en;
    logic              w_par_en;

    assign w_start   = (r_state == S_IDLE) && rx_valid && rx_bit;
    assign w_cnt_ok  = (r_cnt < CNT_W'(DATA_W));
    assign w_last    = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_data_en = (r_state == S_DATA) && rx_valid && w_cnt_ok;
    assign w_par_en  = (r_state == S_PARITY) && rx_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_DATA;
            // An out-of-range counter can only come from corruption; recover.
            S_DATA:   if (!w_cnt_ok) w_next = S_IDLE;
                      else if (rx_valid && w_last) w_next = S_PARITY;
            S_PARITY: if (rx_valid) w_next = S_HOLD;
            S_HOLD:   if (out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_out_data   <= '0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= (r_state == S_HOLD) && rx_valid;
            if (w_start) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end
            if (w_data_en) begin
                for (int i = 0; i < DATA_W; i++) begin
                    if (r_cnt == CNT_W'(i)) r_shift[i] <= rx_bit;
                end
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_par_en) begin
                r_out_data   <= r_shift;
                r_parity_err <= w_acc ^ rx_bit ^ PARITY_ODD;
            end
        end
    end

    parity_acc u_parity_acc (
        .clk   (clk),
        .rst   (reset),
        .i_clr (w_start),
        .i_en  (w_data_en),
        .i_bit (rx_bit),
        .o_acc (w_acc)
    );

    assign out_data   = r_out_data;
    assign out_valid  = (r_state == S_HOLD);
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire
